rr_priority_arbiter: RTL and testbench

- Four-requester arbiter that shares one downstream resource, such as the encoder-fed bus, between requesters 0..3.
- Selectable mode:
  - fixed priority: highest index wins, matching the priority-encoder convention where I[3] is the top bit;
  - round-robin: rotating priority.
- Grants are held until the owner drops its request or a hold-time limit expires.
- Sits between requester logic and the shared resource's select/mux.

---
 rtl/rr_priority_arbiter.sv | 109 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_priority_arbiter.sv
// Four-requester arbiter with selectable fixed-priority or round-robin arbitration.
// The arbiter holds a grant until the owner drops its request or MAX_HOLD cycles have elapsed.
module rr_priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       rr_en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StGrant} state_e;

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]       last_id_q, last_id_d;
  logic [1:0]       win_id;

  // Scan from lowest to highest priority so that the last hit is the winner.
  always_comb begin
    logic [1:0] idx;
    win_id = 2'd0;
    idx    = 2'd0;
    if (rr_en) begin
      for (int k = 4; k >= 1; k--) begin
        idx = last_id_q + 2'(k);
        if (req[idx]) win_id = idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) win_id = 2'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    last_id_d   = last_id_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        gnt_d       = 4'b0000;
        gnt_id_d    = 2'd0;
        gnt_valid_d = 1'b0;
        if (|req) begin
          state_d     = StGrant;
          gnt_d       = 4'b0001 << win_id;
          gnt_id_d    = win_id;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          last_id_d   = win_id;
        end
      end
      StGrant: begin
        if (!req[gnt_id_q] || hold_cnt_q == HoldLast) begin
          state_d     = StIdle;
          gnt_d       = 4'b0000;
          gnt_id_d    = 2'd0;
          gnt_valid_d = 1'b0;
          // An owner that drops on the limit cycle counts as a normal release.
          timeout_d   = req[gnt_id_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_id_q   <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_id_q   <= last_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Randomised bench for rr_priority_arbiter, checked against a cycle-level behavioural model,
// plus directed scenarios with literal expectations.
module tb_rr_priority_arbiter;

  localparam int MaxHold = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rr_en;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_priority_arbiter #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .rr_en    (rr_en),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural model: the owner index (-1 when none), the number of cycles granted so far,
  // and the last winner.
  int m_owner = -1;
  int m_len   = 0;
  int m_last  = 3;
  bit m_tmo   = 1'b0;
  bit m_init  = 1'b0;

  function automatic int pick(input logic [3:0] r, input logic rr, input int last);
    int w;
    w = -1;
    if (rr) begin
      for (int k = 4; k >= 1; k--) if (r[(last + k) % 4]) w = (last + k) % 4;
    end else begin
      for (int i = 0; i < 4; i++) if (r[i]) w = i;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_len = 0; m_last = 3; m_tmo = 1'b0; m_init = 1'b1;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      if (req != 4'b0000) begin
        m_owner = pick(req, rr_en, m_last);
        m_last  = m_owner;
        m_len   = 1;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_tmo = 1'b0;
    end else if (m_len == MaxHold) begin
      m_owner = -1; m_tmo = 1'b1;
    end else begin
      m_len++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_gnt;
    logic [1:0] e_id;
    if (m_init) begin
      e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      e_id  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
      n_cmp++;
      if (gnt !== e_gnt || gnt_id !== e_id || gnt_valid !== (m_owner >= 0) || timeout !== m_tmo) begin
        n_err++;
        $display("FAIL model t=%0t: got gnt=%b id=%0d v=%b tmo=%b, want gnt=%b id=%0d v=%b tmo=%b",
                 $time, gnt, gnt_id, gnt_valid, timeout, e_gnt, e_id, m_owner >= 0, m_tmo);
      end
      n_cmp++;
      if ((gnt & (gnt - 4'd1)) != 4'd0 || gnt_valid !== (|gnt) || (timeout && gnt_valid)) begin
        n_err++;
        $display("FAIL invariant t=%0t: got gnt=%b v=%b tmo=%b, want one-hot/zero, v=|gnt, no tmo",
                 $time, gnt, gnt_valid, timeout);
      end
    end
  end

  task automatic cyc(input logic [3:0] r, input logic e, input logic rs);
    req = r; rr_en = e; rst = rs;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] g, input logic [1:0] id, input logic t);
    n_cmp++;
    if (gnt !== g || gnt_id !== id || timeout !== t || gnt_valid !== (|g)) begin
      n_err++;
      $display("FAIL %s: got gnt=%b id=%0d tmo=%b v=%b, want gnt=%b id=%0d tmo=%b",
               name, gnt, gnt_id, timeout, gnt_valid, g, id, t);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       e;
    int         order[5];
    order = '{0, 1, 2, 3, 0};
    req = 4'b1111; rr_en = 1'b0; rst = 1'b1;

    // Reset and idle
    cyc(4'b1111, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1);
    chk("reset", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("idle", 4'b0000, 2'd0, 1'b0);

    // Fixed priority
    cyc(4'b0110, 1'b0, 1'b0);
    chk("fixed_0110", 4'b0100, 2'd2, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("fixed_release", 4'b0000, 2'd0, 1'b0);

    // Round-robin rotation with forced releases
    cyc(4'b1111, 1'b1, 1'b1);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < MaxHold; c++) begin
        cyc(4'b1111, 1'b1, 1'b0);
        chk($sformatf("rr_hold_%0d_%0d", g, c), 4'(1 << order[g]), 2'(order[g]), 1'b0);
      end
      cyc(4'b1111, 1'b1, 1'b0);
      chk($sformatf("rr_timeout_%0d", g), 4'b0000, 2'd0, 1'b1);
    end

    // Sparse round-robin and wrap-around
    cyc(4'b1000, 1'b1, 1'b0);
    chk("rr_id3", 4'b1000, 2'd3, 1'b0);
    cyc(4'b0101, 1'b1, 1'b0);
    chk("rr_id3_rel", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0101, 1'b1, 1'b0);
    chk("rr_wrap_id0", 4'b0001, 2'd0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("rr_id0_rel", 4'b0000, 2'd0, 1'b0);
    cyc(4'b0101, 1'b1, 1'b0);
    chk("rr_next_id2", 4'b0100, 2'd2, 1'b0);
    cyc(4'b0000, 1'b1, 1'b0);

    // Non-owner and mode changes ignored
    cyc(4'b0010, 1'b1, 1'b0);
    chk("own1", 4'b0010, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc((i % 2 == 0) ? 4'b1011 : 4'b0010, 1'(i % 2), 1'b0);
      chk($sformatf("own1_hold_%0d", i), 4'b0010, 2'd1, 1'b0);
    end
    cyc(4'b0000, 1'b0, 1'b0);

    // Owner drops exactly on the hold limit
    cyc(4'b1000, 1'b0, 1'b0);
    chk("lim_grant", 4'b1000, 2'd3, 1'b0);
    for (int c = 1; c < MaxHold; c++) cyc(4'b1000, 1'b0, 1'b0);
    chk("lim_last", 4'b1000, 2'd3, 1'b0);
    cyc(4'b0000, 1'b0, 1'b0);
    chk("lim_drop", 4'b0000, 2'd0, 1'b0);

    // Fixed mode: a timed-out owner is re-granted after the idle cycle
    cyc(4'b1001, 1'b0, 1'b0);
    for (int c = 1; c < MaxHold; c++) cyc(4'b1001, 1'b0, 1'b0);
    cyc(4'b1001, 1'b0, 1'b0);
    chk("fix_tmo", 4'b0000, 2'd0, 1'b1);
    cyc(4'b1001, 1'b0, 1'b0);
    chk("fix_regrant", 4'b1000, 2'd3, 1'b0);

    // Reset mid-grant
    cyc(4'b0001, 1'b0, 1'b1);
    cyc(4'b0001, 1'b0, 1'b0);
    cyc(4'b0001, 1'b0, 1'b0);
    chk("mid_grant", 4'b0001, 2'd0, 1'b0);
    cyc(4'b0001, 1'b1, 1'b1);
    chk("mid_reset", 4'b0000, 2'd0, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0);
    chk("post_reset_rr", 4'b0001, 2'd0, 1'b0);

    // Randomised traffic with sticky requests so that timeouts happen
    r = 4'b0000; e = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) e = ~e;
      cyc(r, e, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
